// File: rtl/traffic_generator.sv
// traffic_generator: LFSR-driven per-node packet source feeding a small FIFO; stats counters need TRAFFIC_GEN_STATS_EN.
// Latency: decision edge enqueues, head valid the following cycle; no bypass path.
// Backpressure: pkt_ready low holds the head stable; a full queue without a pop drops the new packet.

// traffic_generator_fifo: circular queue with synchronous clear.
// Latency: push visible at the head one cycle later; head read combinationally.
// Backpressure: accepts a push when not full or when popping in the same cycle.
module traffic_generator_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty when the index bits match.
    assign pop_vld = (rd_ptr != wr_ptr);
    assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign do_pop  = pop_vld && pop_rdy;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is reset so an idle head presents all-zero fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end
endmodule

module traffic_generator #(
    parameter int          NODE_ID             = 0,
    parameter int          NUM_NODES           = 16,
    parameter int          MAX_CYCLE_WIDTH     = 32,
    parameter logic [8:0]  INJECTION_THRESHOLD = 9'd32,
    parameter int          FIFO_DEPTH          = 4,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   sim_state,
    input  logic [MAX_CYCLE_WIDTH-1:0]   current_cycle,
    output logic                         pkt_valid,
    input  logic                         pkt_ready,
    output logic [$clog2(NUM_NODES)-1:0] pkt_src,
    output logic [$clog2(NUM_NODES)-1:0] pkt_dest,
    output logic [15:0]                  pkt_id,
    output logic [MAX_CYCLE_WIDTH-1:0]   pkt_timestamp,
    output logic [31:0]                  injected_count,
    output logic [31:0]                  dropped_count,
    output logic                         drained
);
    localparam int          NW      = $clog2(NUM_NODES);
    localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [NW-1:0] SELF  = NW'(NODE_ID);
    localparam logic [NW-1:0] OTHER = NW'((NODE_ID + 1) % NUM_NODES);

    typedef enum logic [1:0] {
        ST_INVALID = 2'b00,
        ST_INIT    = 2'b01,
        ST_RUN     = 2'b10,
        ST_DONE    = 2'b11
    } sim_state_t;

    typedef struct packed {
        logic [NW-1:0]              dest;
        logic [15:0]                id;
        logic [MAX_CYCLE_WIDTH-1:0] ts;
    } pkt_t;

    sim_state_t    st;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_next;
    logic [15:0]   id_q;
    logic [NW-1:0] cand_dest;
    logic [NW-1:0] dest;
    logic          inject_req;
    logic          fifo_full;
    logic          pop;
    logic          push;
    pkt_t          push_pkt;
    pkt_t          head_pkt;

    assign st = sim_state_t'(sim_state);

    always_comb begin
        lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        cand_dest  = lfsr_q[8 +: NW];
        dest       = (cand_dest == SELF) ? OTHER : cand_dest;
        inject_req = (st == ST_RUN) && ({1'b0, lfsr_q[7:0]} < INJECTION_THRESHOLD);
    end

    assign pop      = pkt_valid && pkt_ready;
    assign push     = inject_req && (!fifo_full || pop);
    assign push_pkt = '{dest: dest, id: id_q, ts: current_cycle};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
            id_q   <= '0;
        end else begin
            case (st)
                ST_INIT: begin
                    lfsr_q <= SEED;
                    id_q   <= '0;
                end
                ST_RUN: begin
                    lfsr_q <= lfsr_next;
                    if (push) id_q <= id_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    traffic_generator_fifo #(
        .WIDTH ($bits(pkt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (st == ST_INIT),
        .push_vld (push),
        .push_dat (push_pkt),
        .full     (fifo_full),
        .pop_vld  (pkt_valid),
        .pop_rdy  (pkt_ready),
        .pop_dat  (head_pkt)
    );

    assign pkt_src       = SELF;
    assign pkt_dest      = head_pkt.dest;
    assign pkt_id        = head_pkt.id;
    assign pkt_timestamp = head_pkt.ts;
    assign drained       = (st == ST_DONE) && !pkt_valid;

`ifdef TRAFFIC_GEN_STATS_EN
    logic        drop;
    logic [31:0] injected_q;
    logic [31:0] dropped_q;

    assign drop = inject_req && fifo_full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            injected_q <= '0;
            dropped_q  <= '0;
        end else if (st == ST_INIT) begin
            injected_q <= '0;
            dropped_q  <= '0;
        end else begin
            if (push && injected_q != 32'hFFFF_FFFF) injected_q <= injected_q + 32'd1;
            if (drop && dropped_q != 32'hFFFF_FFFF)  dropped_q  <= dropped_q + 32'd1;
        end
    end

    assign injected_count = injected_q;
    assign dropped_count  = dropped_q;
`else
    assign injected_count = '0;
    assign dropped_count  = '0;
`endif
endmodule

// File: tb/tb_traffic_generator.sv
// Scoreboard bench for traffic_generator: reference model queues expected packets, a negedge monitor pops and compares.
module tb_traffic_generator;
    localparam int          NN_A  = 4;
    localparam int          ID_A  = 1;
    localparam int          DEP_A = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sim_state = 2'b00;
    logic [31:0] current_cycle = 32'd0;
    logic        ready_a = 1'b0;

    logic        valid_a, drained_a;
    logic [1:0]  src_a, dest_a;
    logic [15:0] id_a;
    logic [31:0] ts_a, inj_a, drop_a;

    logic        valid_b, drained_b;
    logic [2:0]  src_b, dest_b;
    logic [15:0] id_b;
    logic [31:0] ts_b, inj_b, drop_b;

    always #5 clk = ~clk;

    traffic_generator #(
        .NODE_ID(ID_A), .NUM_NODES(NN_A), .MAX_CYCLE_WIDTH(32),
        .INJECTION_THRESHOLD(9'd256), .FIFO_DEPTH(DEP_A), .LFSR_SEED(SEED)
    ) dut_a (
        .clk(clk), .reset(reset), .sim_state(sim_state), .current_cycle(current_cycle),
        .pkt_valid(valid_a), .pkt_ready(ready_a), .pkt_src(src_a), .pkt_dest(dest_a),
        .pkt_id(id_a), .pkt_timestamp(ts_a), .injected_count(inj_a),
        .dropped_count(drop_a), .drained(drained_a)
    );

    traffic_generator #(
        .NODE_ID(5), .NUM_NODES(8), .MAX_CYCLE_WIDTH(32),
        .INJECTION_THRESHOLD(9'd0), .FIFO_DEPTH(4), .LFSR_SEED(16'h1234)
    ) dut_b (
        .clk(clk), .reset(reset), .sim_state(sim_state), .current_cycle(current_cycle),
        .pkt_valid(valid_b), .pkt_ready(1'b1), .pkt_src(src_b), .pkt_dest(dest_b),
        .pkt_id(id_b), .pkt_timestamp(ts_b), .injected_count(inj_b),
        .dropped_count(drop_b), .drained(drained_b)
    );

    typedef struct {
        int     dest;
        int     id;
        longint ts;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_lfsr;
    int          m_id, m_occ;
    longint      m_inj, m_drop;
    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] stat(input longint v);
`ifdef TRAFFIC_GEN_STATS_EN
        return 64'(v);
`else
        return 64'(v - v);
`endif
    endfunction

    function automatic logic [15:0] galois_step(input logic [15:0] x);
        if (x[0]) return (x >> 1) ^ 16'hB400;
        return x >> 1;
    endfunction

    task automatic model_clear();
        m_lfsr = SEED;
        m_id   = 0;
        m_occ  = 0;
        m_inj  = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    // Reference model: applies the injection/drop/drain rules at every active edge.
    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
            end else begin
                bit   pop;
                int   d;
                exp_t e;
                pop = (m_occ > 0) && ready_a;
                if (sim_state == 2'b01) begin
                    model_clear();
                end else begin
                    if (sim_state == 2'b10) begin
                        if (int'(m_lfsr[7:0]) < 256) begin
                            d = int'(m_lfsr[15:8]) % NN_A;
                            if (d == ID_A) d = (ID_A + 1) % NN_A;
                            if (m_occ < DEP_A || pop) begin
                                e.dest = d;
                                e.id   = m_id;
                                e.ts   = longint'(current_cycle);
                                exp_q.push_back(e);
                                m_id = (m_id + 1) % 65536;
                                m_inj++;
                                m_occ++;
                            end else begin
                                m_drop++;
                            end
                        end
                        m_lfsr = galois_step(m_lfsr);
                    end
                    if (pop) m_occ--;
                end
            end
        end
    end

    // Monitor: compare the presented head with the scoreboard front; retire it on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("valid_a", 64'(valid_a), 64'(m_occ > 0));
                if (valid_a) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pkt", 64'(valid_a), 64'd0);
                    end else begin
                        chk("dest_a", 64'(dest_a), 64'(exp_q[0].dest));
                        chk("id_a", 64'(id_a), 64'(exp_q[0].id));
                        chk("ts_a", 64'(ts_a), 64'(exp_q[0].ts));
                        if (ready_a) begin
                            void'(exp_q.pop_front());
                            pop_cnt++;
                        end
                    end
                end
                chk("inj_a", 64'(inj_a), stat(m_inj));
                chk("drop_a", 64'(drop_a), stat(m_drop));
                chk("drained_a", 64'(drained_a), 64'((sim_state == 2'b11) && (m_occ == 0)));
                chk("valid_b", 64'(valid_b), 64'd0);
                chk("inj_b", 64'(inj_b), 64'd0);
                chk("drop_b", 64'(drop_b), 64'd0);
            end
        end
    end

    task automatic run(input logic [1:0] st, input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            sim_state = st;
            ready_a   = rdy;
            @(posedge clk);
            #1;
            current_cycle = current_cycle + 32'd1;
        end
    endtask

    initial begin
        int pops_before;
        #12;
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_dest", 64'(dest_a), 64'd0);
        chk("rst_id", 64'(id_a), 64'd0);
        chk("rst_ts", 64'(ts_a), 64'd0);
        chk("rst_inj", 64'(inj_a), 64'd0);
        chk("rst_drop", 64'(drop_a), 64'd0);
        chk("rst_drained", 64'(drained_a), 64'd0);
        chk("src_a", 64'(src_a), 64'd1);
        chk("src_b", 64'(src_b), 64'd5);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Continuous injection, always ready.
        run(2'b00, 1'b1, 2);
        run(2'b01, 1'b1, 1);
        chk("t1_no_valid_first_run_cycle", 64'(valid_a), 64'd0);
        run(2'b10, 1'b1, 1);
        chk("t1_valid_second_cycle", 64'(valid_a), 64'd1);
        chk("t1_first_id", 64'(id_a), 64'd0);
        run(2'b10, 1'b1, 19);

        // Stalled consumer: queue fills, rest dropped.
        run(2'b01, 1'b0, 1);
        run(2'b10, 1'b0, 10);
        chk("t2_inj", 64'(inj_a), stat(4));
        chk("t2_drop", 64'(drop_a), stat(6));
        chk("t2_head_id", 64'(id_a), 64'd0);
        run(2'b10, 1'b1, 6);
        chk("t3_drop_held", 64'(drop_a), stat(6));

        // Drain after completion.
        run(2'b01, 1'b0, 1);
        run(2'b10, 1'b0, 3);
        pops_before = pop_cnt;
        run(2'b11, 1'b1, 6);
        chk("t4_pops", 64'(pop_cnt - pops_before), 64'd3);
        chk("t4_drained", 64'(drained_a), 64'd1);
        chk("t4_valid", 64'(valid_a), 64'd0);

        // Asynchronous reset with entries queued.
        run(2'b01, 1'b0, 1);
        run(2'b10, 1'b0, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_valid_async", 64'(valid_a), 64'd0);
        chk("t5_inj_async", 64'(inj_a), 64'd0);
        chk("t5_drop_async", 64'(drop_a), 64'd0);
        chk("t5_id_async", 64'(id_a), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(2'b00, 1'b1, 1);
        run(2'b01, 1'b1, 1);
        run(2'b10, 1'b1, 12);

        // Randomized consumer and controller states.
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [1:0] st;
            r = $urandom_range(0, 99);
            st = (r < 75) ? 2'b10 : (r < 88) ? 2'b11 : (r < 95) ? 2'b00 : 2'b01;
            sim_state = st;
            ready_a   = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
            current_cycle = current_cycle + 32'($urandom_range(0, 3));
        end

        run(2'b11, 1'b1, 8);
        chk("final_inj_b", 64'(inj_b), 64'd0);
        chk("final_drained_a", 64'(drained_a), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
